// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I instruction fields into 32-bit words,
// range-checks the immediate, and queues {err, instr, addr} in a small FIFO
// feeding the instruction-memory write port with sequential word addresses.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_fmt,
  input  logic [6:0]                    in_opcode,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [2:0]                    in_funct3,
  input  logic [6:0]                    in_funct7,
  input  logic [31:0]                   in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic                          out_err,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          err_seen,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Instruction formats as presented on in_fmt; 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic              err;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_instr;
  logic               enc_err;
  logic               push;
  logic               pop;
  entry_t             head;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               err_seen_q, err_seen_d;

  assign imm_s = $signed(in_imm);

  // Pack the fields per format and flag immediates that do not fit; the word
  // is still built from the truncated bits so the loader can see what it got.
  always_comb begin
    enc_instr = NOP_WORD;
    enc_err   = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = |in_imm[11:0];
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
      end
      default: begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Handshake: accept only when there is room, independent of the consumer,
  // so a full FIFO never pushes and pops in the same cycle.
  assign in_ready  = (level_q < LVL_W'(FIFO_DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head fields read as zero while the FIFO is empty so a freshly reset
  // block presents an all-zero output bus.
  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head.instr : 32'h0;
  assign out_err   = out_valid ? head.err   : 1'b0;
  assign out_addr  = out_valid ? head.addr  : '0;
  assign err_seen  = err_seen_q;
  assign level     = level_q;

  // Next-state for FIFO storage, pointers, occupancy, address counter and the
  // sticky error flag; pointers wrap naturally because the depth is 2^n.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    addr_d     = addr_q;
    err_seen_d = err_seen_q;

    if (push) begin
      mem_d[wr_ptr_q].err   = enc_err;
      mem_d[wr_ptr_q].instr = enc_instr;
      mem_d[wr_ptr_q].addr  = addr_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      addr_d                = addr_q + ADDR_W'(1);
      err_seen_d            = err_seen_q | enc_err;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset discards all queued words and restarts addressing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      addr_q     <= '0;
      err_seen_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      addr_q     <= addr_d;
      err_seen_q <= err_seen_d;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake, packs them into a 32-bit instruction word, range-checks the immediate, and buffers results in a small output FIFO. It is the inverse of the core's immediate-generation/decode path. It sits between the boot/test loader and the instruction-memory write port, and supplies a sequential write address with each word.

## Interface
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
- ADDR_W, 10, width of instruction-memory word address
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle present
- in_ready  out  1  bundle accepted when in_valid && in_ready at clk edge
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- in_opcode  in  7  opcode[6:0]
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  full signed immediate (byte offset for B/J; full value for U)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid && out_ready
- out_instr  out  32  encoded word
- out_err  out  1  head word had illegal format or out-of-range immediate
- out_addr  out  ADDR_W  word address of head
- err_seen  out  1  sticky, set by any accepted erroneous bundle
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Encoding (combinational from inputs, written to FIFO on accept):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range checks (error => word still encoded from truncated bits, err=1):
  - I/S: -2048..2047
  - B: -4096..4094, imm[0]==0
  - J: -1048576..1048574, imm[0]==0
  - U: imm[11:0]==0
  - R: no check (imm ignored)
  - fmt 6/7: word forced to 32'h0000_0013 (NOP), err=1
- FIFO stores {err, instr, addr}. Address counter starts at 0, increments by 1 per accepted bundle, wraps from 2^ADDR_W-1 to 0 silently.
- err_seen set on accept of err bundle; cleared only by reset.

## Timing
- Reset (async assert, sync release): FIFO empty, level=0, out_valid=0, out_instr=0, out_err=0, out_addr=0, addr counter=0, err_seen=0, in_ready=1.
- in_ready = (level < FIFO_DEPTH); does not depend on out_ready (no same-cycle push-on-pop when full).
- Latency: bundle accepted at edge N appears at head with out_valid=1 after edge N (visible in cycle N+1) if FIFO was empty; otherwise in order.
- Simultaneous push and pop with 0<level<FIFO_DEPTH: level unchanged, order preserved.
- out_instr/out_err/out_addr stable while out_valid && !out_ready.
- Reset mid-stream discards all FIFO contents; no partial word emitted.
- Full throughput: one word per cycle when out_ready held high.

## Test plan
- Reset then I-type addi (op 0x13, rd 1, rs1 0, f3 0, imm 5) -> out_instr 0x00500093, out_err 0, out_addr 0, out_valid one cycle after accept.
- Back-to-back S sw (op 0x23, rs1 1, rs2 2, f3 2, imm 8), B beq (op 0x63, imm -4), U lui (op 0x37, rd 5, imm 0x12345000), J jal (op 0x6F, rd 1, imm 2048) -> 0x0020A423, 0xFE000EE3, 0x123452B7, 0x001000EF, addrs 1..4.
- Errors: I imm 2048, B imm 3, U imm 0x12345001, fmt 7 -> each out_err=1, fmt 7 word 0x00000013, err_seen=1 and stays 1.
- Backpressure: out_ready=0, push 5 bundles -> in_ready drops after 4th, level=4, head stable; release out_ready -> 5th accepted, order preserved.
- Simultaneous push/pop at level 2 for 10 cycles -> level stays 2, data in order; address wrap with ADDR_W=2 -> addrs 3 then 0.
- Assert rst_n low with level 3 -> out_valid=0, level=0 immediately; next accepted word gets addr 0.
